// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller.
//   ctrl_state_e        : 4-bit FSM state encoding, also driven out on state_o.
//   TIMEOUT_CYC_DEFAULT : default cycle budget for any memory request/wait state.
package ctrl_pkg;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StFetchReq  = 4'd1,
    StFetchWait = 4'd2,
    StDecode    = 4'd3,
    StExec      = 4'd4,
    StMemReq    = 4'd5,
    StMemWait   = 4'd6,
    StWb        = 4'd7,
    StHalt      = 4'd8,
    StErr       = 4'd9
  } ctrl_state_e;

  // States that wait on a memory handshake and are therefore timed.
  function automatic logic is_wait_state(ctrl_state_e s);
    return s inside {StFetchReq, StFetchWait, StMemReq, StMemWait};
  endfunction

endpackage

// File: rtl/ctrl_wdog.sv
// Timeout counter for the multicycle controller.
//   clk, rst  : clock and asynchronous active-high reset
//   clear_i   : zero the count (takes priority over enable_i)
//   enable_i  : count this cycle
//   limit_i   : number of cycles allowed
//   expired_o : the current cycle is the limit_i-th enabled cycle
module ctrl_wdog #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [Width-1:0] limit_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  // cnt_q counts cycles already spent, so the current cycle is number cnt_q + 1.
  assign expired_o = enable_i &&
                     ((Width + 1)'(cnt_q) + (Width + 1)'(1) >= (Width + 1)'(limit_i));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU sequencing controller.
//   imem_* : instruction fetch handshake (request, accept, data return)
//   dmem_* : data access handshake; dmem_we_o marks a store
//   dec_*  : decoded attributes of the latched instruction
//   ir_we_o / reg_we_o / pc_we_o : datapath enables
//   halt_o / err_o : sticky terminal states (ebreak, timeout or illegal decode)
//   state_o, cycle_o, instret_o : state encoding and performance counters
// Every output is a flop loaded from the next-state decode, so outputs line up with
// state_q and there is no combinational path from any input to any output.
module multicycle_ctrl import ctrl_pkg::*; #(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter int unsigned XLEN        = 64
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_valid_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  output logic            dmem_valid_o,
  output logic            dmem_we_o,
  input  logic            dmem_ready_i,
  input  logic            dmem_rvalid_i,
  input  logic            dec_load_i,
  input  logic            dec_store_i,
  input  logic            dec_reg_we_i,
  input  logic            dec_break_i,
  output logic            ir_we_o,
  output logic            reg_we_o,
  output logic            pc_we_o,
  output logic            halt_o,
  output logic            err_o,
  output logic [3:0]      state_o,
  output logic [XLEN-1:0] cycle_o,
  output logic [XLEN-1:0] instret_o
);

  localparam int unsigned WdogW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  ctrl_state_e     state_q, state_d;
  logic            wdog_expired;
  logic [XLEN-1:0] cycle_q, instret_q;

  ctrl_wdog #(
    .Width(WdogW)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_d != state_q),
    .enable_i (is_wait_state(state_q)),
    .limit_i  (WdogW'(TIMEOUT_CYC)),
    .expired_o(wdog_expired)
  );

  // Exit conditions are tested before the timeout so a late handshake still wins.
  // rvalid is only looked at in the *_WAIT states.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      state_d = StFetchReq;
      StFetchReq: begin
        if (imem_ready_i)      state_d = StFetchWait;
        else if (wdog_expired) state_d = StErr;
      end
      StFetchWait: begin
        if (imem_rvalid_i)     state_d = StDecode;
        else if (wdog_expired) state_d = StErr;
      end
      StDecode:    state_d = dec_break_i ? StHalt : StExec;
      StExec: begin
        if (dec_load_i && dec_store_i)      state_d = StErr;
        else if (dec_load_i || dec_store_i) state_d = StMemReq;
        else                                state_d = StWb;
      end
      StMemReq: begin
        if (dmem_ready_i)      state_d = StMemWait;
        else if (wdog_expired) state_d = StErr;
      end
      StMemWait: begin
        if (dmem_rvalid_i)     state_d = StWb;
        else if (wdog_expired) state_d = StErr;
      end
      StWb:        state_d = StFetchReq;
      StHalt:      state_d = StHalt;
      StErr:       state_d = StErr;
      default:     state_d = StErr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      imem_valid_o <= 1'b0;
      dmem_valid_o <= 1'b0;
      dmem_we_o    <= 1'b0;
      ir_we_o      <= 1'b0;
      reg_we_o     <= 1'b0;
      pc_we_o      <= 1'b0;
      halt_o       <= 1'b0;
      err_o        <= 1'b0;
      cycle_q      <= '0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      imem_valid_o <= (state_d == StFetchReq);
      dmem_valid_o <= (state_d == StMemReq);
      dmem_we_o    <= (state_d == StMemReq) && dec_store_i;
      ir_we_o      <= (state_d == StDecode);
      reg_we_o     <= (state_d == StWb) && dec_reg_we_i && !dec_store_i;
      pc_we_o      <= (state_d == StWb);
      halt_o       <= (state_d == StHalt);
      err_o        <= (state_d == StErr);
      if (!(state_q inside {StIdle, StHalt, StErr})) begin
        cycle_q <= cycle_q + XLEN'(1);
      end
      // Retire at the end of the WB cycle.
      if (state_q == StWb) begin
        instret_q <= instret_q + XLEN'(1);
      end
    end
  end

  assign state_o   = state_q;
  assign cycle_o   = cycle_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int EvIr = 0, EvWb = 1, EvHalt = 2, EvErr = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic imem_ready_i = 1'b0, imem_rvalid_i = 1'b0, dmem_ready_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic dec_load_i = 1'b0, dec_store_i = 1'b0, dec_reg_we_i = 1'b0, dec_break_i = 1'b0;
  logic imem_valid_o, dmem_valid_o, dmem_we_o, ir_we_o, reg_we_o, pc_we_o, halt_o, err_o;
  logic [3:0]      state_o;
  logic [XLEN-1:0] cycle_o, instret_o;

  multicycle_ctrl #(
    .TIMEOUT_CYC(4),
    .XLEN       (XLEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_valid_o (imem_valid_o),
    .imem_ready_i (imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i),
    .dmem_valid_o (dmem_valid_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_ready_i (dmem_ready_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dec_load_i   (dec_load_i),
    .dec_store_i  (dec_store_i),
    .dec_reg_we_i (dec_reg_we_i),
    .dec_break_i  (dec_break_i),
    .ir_we_o      (ir_we_o),
    .reg_we_o     (reg_we_o),
    .pc_we_o      (pc_we_o),
    .halt_o       (halt_o),
    .err_o        (err_o),
    .state_o      (state_o),
    .cycle_o      (cycle_o),
    .instret_o    (instret_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     kind;
    longint cyc;
    longint ret;
    logic   rwe;
    int     memc;
    logic   we;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, errors = 0, ev_n = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int kind, input longint cyc, input longint ret, input logic rwe,
                      input int memc, input logic we);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.ret = ret; e.rwe = rwe; e.memc = memc; e.we = we;
    exp_q.push_back(e);
  endtask

  // Monitor: records DUT output events and checks them against the scoreboard queue.
  int   memc = 0;
  logic we_seen = 1'b0, prev_halt = 1'b0, prev_err = 1'b0;

  task automatic sb_compare(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event",
               kind, cycle_o);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("ev%0d_kind", ev_n), kind, e.kind);
      check($sformatf("ev%0d_cycle", ev_n), longint'(cycle_o), e.cyc);
      check($sformatf("ev%0d_instret", ev_n), longint'(instret_o), e.ret);
      if (e.kind == EvWb) begin
        check($sformatf("ev%0d_reg_we", ev_n), longint'(reg_we_o), longint'(e.rwe));
        check($sformatf("ev%0d_dmem_req_cycles", ev_n), memc, e.memc);
        check($sformatf("ev%0d_dmem_we", ev_n), longint'(we_seen), longint'(e.we));
      end
      if (e.kind == EvErr) check($sformatf("ev%0d_dmem_req_cycles", ev_n), memc, e.memc);
    end
    ev_n++;
  endtask

  always @(negedge clk) begin
    int kind;
    kind = -1;
    if (rst) begin
      memc = 0; we_seen = 1'b0; prev_halt = 1'b0; prev_err = 1'b0;
    end else begin
      if (dmem_valid_o) memc++;
      if (dmem_we_o) we_seen = 1'b1;
      if (ir_we_o)                     kind = EvIr;
      else if (pc_we_o)                kind = EvWb;
      else if (halt_o && !prev_halt)   kind = EvHalt;
      else if (err_o && !prev_err)     kind = EvErr;
      prev_halt = halt_o;
      prev_err  = err_o;
      if (kind >= 0) begin
        sb_compare(kind);
        if (kind == EvIr) begin
          memc = 0; we_seen = 1'b0;
        end
      end
    end
  end

  // Driver: answers the DUT handshakes with the given delays until WB/HALT/ERR.
  task automatic do_instr(input int frd, input int frv, input int mrd, input int mrv,
                          input bit rv_in_req, input logic ld, input logic st,
                          input logic rwe, input logic brk);
    int fr = 0, fw = 0, mr = 0, mw = 0;
    bit done = 0;
    dec_load_i = ld; dec_store_i = st; dec_reg_we_i = rwe; dec_break_i = brk;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk); #1;
      imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0;
      case (state_o)
        StFetchReq:  begin imem_ready_i = (fr == frd); fr++; end
        StFetchWait: begin imem_rvalid_i = (fw == frv); fw++; end
        StMemReq: begin
          dmem_ready_i  = (mr == mrd);
          dmem_rvalid_i = rv_in_req && (mr == mrd);
          mr++;
        end
        StMemWait:   begin dmem_rvalid_i = (mw == mrv); mw++; end
        StWb, StHalt, StErr: done = 1;
        default: ;
      endcase
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL instr_bound: got state %0d after 64 cycles, required WB/HALT/ERR", state_o);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_state"}, state_o, StIdle);
    check({tag, "_cycle"}, longint'(cycle_o), 0);
    check({tag, "_instret"}, longint'(instret_o), 0);
    check({tag, "_outs"}, {imem_valid_o, dmem_valid_o, dmem_we_o, ir_we_o, reg_we_o, pc_we_o,
                           halt_o, err_o}, 0);
    rst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout: got no end of run, required $finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit seen;
    do_reset("rst0");

    // Zero-wait add.
    push(EvIr, 2, 0, 0, 0, 0);  push(EvWb, 4, 0, 1, 0, 0);
    do_instr(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // Load, dmem_ready_i in the third MEM_REQ cycle.
    push(EvIr, 7, 1, 0, 0, 0);  push(EvWb, 13, 1, 1, 3, 0);
    do_instr(0, 0, 2, 0, 0, 1, 0, 1, 0);
    // Store that also claims a register write.
    push(EvIr, 16, 2, 0, 0, 0); push(EvWb, 20, 2, 0, 1, 1);
    do_instr(0, 0, 0, 0, 0, 0, 1, 1, 0);
    // Handshakes arrive in the 4th (timeout) cycle: exit wins.
    push(EvIr, 29, 3, 0, 0, 0); push(EvWb, 31, 3, 0, 0, 0);
    do_instr(3, 3, 0, 0, 0, 0, 0, 0, 0);
    // Load with ready+rvalid together in MEM_REQ; rvalid only honoured in MEM_WAIT.
    push(EvIr, 34, 4, 0, 0, 0); push(EvWb, 39, 4, 1, 1, 0);
    do_instr(0, 0, 0, 1, 1, 1, 0, 1, 0);
    // ebreak.
    push(EvIr, 42, 5, 0, 0, 0); push(EvHalt, 43, 5, 0, 0, 0);
    do_instr(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    check("halt_sticky", longint'(halt_o), 1);
    check("halt_state", state_o, StHalt);
    check("halt_cycle_frozen", longint'(cycle_o), 43);
    check("halt_instret", longint'(instret_o), 5);
    check("halt_no_fetch", longint'(imem_valid_o), 0);

    do_reset("rst1");

    // Reset abandons a fetch whose data arrives together with rst.
    dec_break_i = 1'b0;
    imem_ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (state_o == StFetchWait) seen = 1;
    end
    check("midrst_reach_fetch_wait", seen, 1);
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b1; rst = 1'b1;
    #1;
    check("midrst_state_idle", state_o, StIdle);
    check("midrst_ir_we", longint'(ir_we_o), 0);
    @(negedge clk);
    rst = 1'b0; imem_rvalid_i = 1'b0;

    // Illegal decode: load and store together.
    push(EvIr, 2, 0, 0, 0, 0);  push(EvErr, 4, 0, 0, 0, 0);
    do_instr(0, 0, 0, 0, 0, 1, 1, 0, 0);
    repeat (3) @(negedge clk);
    check("illegal_err_sticky", longint'(err_o), 1);
    check("illegal_cycle_frozen", longint'(cycle_o), 4);
    check("illegal_no_dmem", longint'(dmem_valid_o), 0);

    do_reset("rst2");

    // Fetch data never returns: ERR after 4 FETCH_WAIT cycles.
    push(EvErr, 5, 0, 0, 0, 0);
    do_instr(0, 99, 0, 0, 0, 0, 0, 0, 0);
    imem_rvalid_i = 1'b1;
    repeat (3) @(negedge clk);
    check("timeout_err_sticky", longint'(err_o), 1);
    check("timeout_state", state_o, StErr);
    check("timeout_cycle_frozen", longint'(cycle_o), 5);
    check("timeout_no_fetch", longint'(imem_valid_o | ir_we_o | halt_o), 0);
    imem_rvalid_i = 1'b0;

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max cycles spent in any memory request/wait state.
REQ-002 SHALL have parameter XLEN, default 64, counter width.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_valid_o  out  1  instruction fetch request.
- imem_ready_i  in  1  fetch request accepted.
- imem_rvalid_i  in  1  instruction data returned.
- dmem_valid_o  out  1  data access request.
- dmem_we_o  out  1  data access is a store.
- dmem_ready_i  in  1  data request accepted.
- dmem_rvalid_i  in  1  load data returned or store acknowledged.
- dec_load_i  in  1  decoded instruction is a load.
- dec_store_i  in  1  decoded instruction is a store.
- dec_reg_we_i  in  1  decoded instruction writes rd.
- dec_break_i  in  1  decoded instruction is ebreak.
- ir_we_o  out  1  latch fetched instruction.
- reg_we_o  out  1  gated register-file write enable.
- pc_we_o  out  1  commit next PC (sequential or jump target).
- halt_o  out  1  halted on ebreak.
- err_o  out  1  error: timeout or illegal decode.
- state_o  out  4  current state encoding.
- cycle_o  out  XLEN  cycle counter.
- instret_o  out  XLEN  retired instruction counter.

Function
REQ-004 SHALL implement Moore FSM: IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR.
REQ-005 SHALL transition IDLE -> FETCH_REQ unconditionally after one cycle.
REQ-006 FETCH_REQ: imem_valid_o=1; imem_ready_i -> FETCH_WAIT.
REQ-007 FETCH_WAIT: imem_rvalid_i -> DECODE, with ir_we_o=1 for exactly that cycle.
REQ-008 DECODE (1 cycle): dec_break_i -> HALT; else -> EXEC.
REQ-009 EXEC (1 cycle): dec_load_i&dec_store_i -> ERR; load or store -> MEM_REQ; else -> WB.
REQ-010 MEM_REQ: dmem_valid_o=1, dmem_we_o=dec_store_i; dmem_ready_i -> MEM_WAIT.
REQ-011 MEM_WAIT: dmem_rvalid_i -> WB; stores also wait for dmem_rvalid_i.
REQ-012 WB (1 cycle): reg_we_o=dec_reg_we_i&~dec_store_i, pc_we_o=1, instret_o+1, -> FETCH_REQ.
REQ-013 HALT and ERR SHALL be sticky until rst; halt_o=1 only in HALT, err_o=1 only in ERR; all request/enable outputs 0 there.
REQ-014 Timeout counter SHALL clear on every state change; in FETCH_REQ/FETCH_WAIT/MEM_REQ/MEM_WAIT it increments per cycle; reaching TIMEOUT_CYC without the exit condition -> ERR.
REQ-015 Exit condition present in the cycle the counter reaches TIMEOUT_CYC SHALL win over timeout.
REQ-016 ready and rvalid asserted together in a *_REQ state SHALL only advance to *_WAIT; rvalid is honoured only in *_WAIT.
REQ-017 cycle_o SHALL increment every cycle outside IDLE/HALT/ERR; both counters wrap modulo 2^XLEN.
REQ-018 Zero-wait-state non-memory instruction SHALL take 5 cycles FETCH_REQ..WB; load/store 7.
REQ-019 All outputs SHALL decode from registered state only (no input-to-output combinational path except none).

Reset
REQ-020 rst SHALL asynchronously force state IDLE, counters 0, timeout 0; all 1-bit outputs 0 during and after reset until FETCH_REQ.
REQ-021 rst mid-transaction SHALL abandon it; no ir_we_o/reg_we_o/pc_we_o pulse results.

Structure
REQ-022 State encoding enum (4-bit) and TIMEOUT_CYC default SHALL live in shared package ctrl_pkg.
REQ-023 Timeout counter SHALL be sub-module ctrl_wdog (clear, enable, limit -> expired).

Verification
REQ-024 Zero-wait add (dec_reg_we_i=1): ir_we_o at cycle 3, reg_we_o+pc_we_o at cycle 5 after IDLE, instret_o=1.
REQ-025 Load, dmem_ready_i delayed 3 cycles: MEM_REQ held 3 cycles, WB reached, reg_we_o=1, instret_o=1.
REQ-026 Store with dec_reg_we_i=1: dmem_we_o=1, reg_we_o=0 in WB, pc_we_o=1.
REQ-027 imem_rvalid_i never asserted, TIMEOUT_CYC=4: ERR after 4 FETCH_WAIT cycles, err_o=1 sticky, cycle_o frozen.
REQ-028 dec_break_i=1 in DECODE: HALT, halt_o=1, instret_o unchanged; rst returns to IDLE with counters 0.
REQ-029 dec_load_i=dec_store_i=1: EXEC -> ERR, no dmem_valid_o pulse.
